// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath: fp16 constants, the fp16 field
// layout, accumulator state encodings and a leading-zero counter used when
// renormalising fp16 sums.
package softmax_pkg;

  localparam int FP16_W = 16;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  localparam int EXP_BIAS = 15;

  // Accumulator FSM encodings (kept as plain constants for older consumers)
  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  typedef struct packed {
    logic       sign;
    logic [4:0] expo;
    logic [9:0] man;
  } fp16_t;

  // Number of leading zeros in a 14-bit mantissa path; 14 when v is zero.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    lzc14 = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) lzc14 = 4'(13 - i);
    end
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational IEEE binary16 adder shared by the adder tree and the packet
// accumulator. Subnormals (inputs and results) flush to signed zero, rounding
// is round-to-nearest-even over an aligned 14-bit mantissa (hidden bit,
// 10 fraction bits, guard, round, sticky).
// Ports:
//   a, b : fp16 operands
//   y    : fp16 sum
module fp16_add
  import softmax_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  fp16_t fa, fb;
  logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  logic              swap;
  logic              big_s, sml_s, eff_sub;
  logic [4:0]        big_e, sml_e, d;
  logic [9:0]        big_m, sml_m;
  logic [13:0]       big14, sml14, sml_sh, sml_al;
  logic              sticky;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic [13:0]       norm;
  logic signed [6:0] exp_n, exp_r;
  logic              round_up, carry;
  logic [9:0]        frac;

  assign fa = a;
  assign fb = b;

  assign a_nan  = (&fa.expo) & (|fa.man);
  assign b_nan  = (&fb.expo) & (|fb.man);
  assign a_inf  = (&fa.expo) & ~(|fa.man);
  assign b_inf  = (&fb.expo) & ~(|fb.man);
  assign a_zero = ~(|fa.expo);
  assign b_zero = ~(|fb.expo);

  always_comb begin
    // Larger magnitude operand drives the result sign and exponent.
    swap  = {fb.expo, fb.man} > {fa.expo, fa.man};
    big_s = swap ? fb.sign : fa.sign;
    big_e = swap ? fb.expo : fa.expo;
    big_m = swap ? fb.man  : fa.man;
    sml_s = swap ? fa.sign : fb.sign;
    sml_e = swap ? fa.expo : fb.expo;
    sml_m = swap ? fa.man  : fb.man;
    d     = big_e - sml_e;

    big14 = {1'b1, big_m, 3'b000};
    sml14 = {1'b1, sml_m, 3'b000};
    if (d > 5'd13) begin
      sml_sh = '0;
      sticky = 1'b1;
    end else begin
      sml_sh = sml14 >> d;
      sticky = |(sml14 & ~(14'h3FFF << d));
    end
    sml_al = {sml_sh[13:1], sml_sh[0] | sticky};

    eff_sub = big_s ^ sml_s;
    if (eff_sub) sum = {1'b0, big14 - sml_al};
    else         sum = {1'b0, big14} + {1'b0, sml_al};

    lz = lzc14(sum[13:0]);
    if (sum[14]) begin
      // Carry out: shift right one place, folding the dropped bit into sticky.
      norm  = {sum[14:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, big_e}) + 7'sd1;
    end else begin
      // Large left shifts only happen when alignment was exact, so the
      // sticky bit is zero and shifting it upward is harmless.
      norm  = sum[13:0] << lz;
      exp_n = $signed({2'b00, big_e}) - $signed({3'b000, lz});
    end

    round_up      = norm[2] & (norm[1] | norm[0] | norm[3]);
    {carry, frac} = {1'b0, norm[12:3]} + {10'b0, round_up};
    exp_r         = exp_n + $signed({6'b000000, carry});

    if (a_nan | b_nan)                 y = FP16_QNAN;
    else if (a_inf & b_inf)            y = (fa.sign == fb.sign) ? a : FP16_QNAN;
    else if (a_inf)                    y = a;
    else if (b_inf)                    y = b;
    else if (a_zero & b_zero)          y = {fa.sign & fb.sign, 15'b0};
    else if (a_zero)                   y = b;
    else if (b_zero)                   y = a;
    else if (!norm[13])                y = FP16_ZERO;  // exact cancellation
    else if (exp_r >= 7'(2 * EXP_BIAS + 1))
                                       y = big_s ? FP16_NEG_INF : FP16_POS_INF;
    else if (exp_r <= 7'sd0)           y = {big_s, 15'b0};
    else                               y = {big_s, exp_r[4:0], frac};
  end

endmodule

// File: rtl/fp16_packet_accumulator.sv
// Accumulates per-beat fp16 partial sums from the adder tree until tlast and
// emits the packet total (softmax denominator) with its beat count as a
// one-beat AXI-Stream packet. One input beat per cycle while accumulating.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   tvalid_in/tready_in/tlast_in/tdata_in : AXI-Stream slave (fp16 beats)
//   tvalid_out/tready_out/tlast_out/tdata_out : AXI-Stream master (total)
//   cnt_out                        : beats accumulated into tdata_out
//
// state | meaning
// ACC   | accepting beats, tready_in high
// OUT   | total presented, tready_in low until downstream accepts
module fp16_packet_accumulator
  import softmax_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tvalid_in,
  output logic             tready_in,
  input  logic             tlast_in,
  input  logic [15:0]      tdata_in,
  output logic             tvalid_out,
  input  logic             tready_out,
  output logic             tlast_out,
  output logic [15:0]      tdata_out,
  output logic [CNT_W-1:0] cnt_out
);

  logic [0:0]       state;
  logic [15:0]      acc, sum, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             first;
  logic             hs;

  fp16_add u_add (
    .a (acc),
    .b (tdata_in),
    .y (sum)
  );

  assign hs      = tvalid_in & tready_in;
  // First beat is loaded raw rather than added to zero, so its value
  // (including sign of zero) passes through untouched.
  assign acc_nxt = first ? tdata_in : sum;
  assign cnt_nxt = first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ACC;
      acc        <= FP16_ZERO;
      cnt        <= '0;
      first      <= 1'b1;
      tvalid_out <= 1'b0;
      tlast_out  <= 1'b0;
      tdata_out  <= FP16_ZERO;
      cnt_out    <= '0;
      tready_in  <= 1'b1;
    end else begin
      case (state)
        ST_ACC: begin
          if (hs) begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            first <= 1'b0;
            if (tlast_in) begin
              tdata_out  <= acc_nxt;
              cnt_out    <= cnt_nxt;
              tvalid_out <= 1'b1;
              tlast_out  <= 1'b1;
              tready_in  <= 1'b0;
              state      <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (tready_out) begin
            tvalid_out <= 1'b0;
            tlast_out  <= 1'b0;
            tready_in  <= 1'b1;
            first      <= 1'b1;
            acc        <= FP16_ZERO;
            cnt        <= '0;
            state      <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule
